// File: rtl/circuit2_pkg.sv
// ---------------------------------------------------------------------------
// circuit2_pkg
// Shared definitions for the circuit2 receiver-side decoder:
//   - state_e   : decoder FSM states
//   - HYP_*     : bit positions inside hyp_mask ({eq, lt, gt})
//   - OP_*      : operation select codes for the shared add/sub unit
//   - pack_hyp  : assembles a hypothesis mask from the three flags
// ---------------------------------------------------------------------------
package circuit2_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SUB_B = 3'd1,
        ADD_D = 3'd2,
        SUB_X = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int HYP_GT = 0;
    localparam int HYP_LT = 1;
    localparam int HYP_EQ = 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Place each flag at its documented bit position in the mask.
    function automatic logic [2:0] pack_hyp(input logic eq, input logic lt, input logic gt);
        logic [2:0] mask;
        mask         = 3'b000;
        mask[HYP_EQ] = eq;
        mask[HYP_LT] = lt;
        mask[HYP_GT] = gt;
        return mask;
    endfunction

endpackage

// File: rtl/circuit2_decode_addsub.sv
// ---------------------------------------------------------------------------
// addsub_unit
// Shared modular adder/subtractor. One adder path and one subtractor path
// feed a result mux steered by op; wrap-around is intentional and unflagged.
// Ports:
//   op     in   OP_ADD / OP_SUB
//   opa    in   left operand
//   opb    in   right operand
//   result out  opa + opb or opa - opb, mod 2^DATAWIDTH
// ---------------------------------------------------------------------------
module addsub_unit
    import circuit2_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 op,
    input  logic [DATAWIDTH-1:0] opa,
    input  logic [DATAWIDTH-1:0] opb,
    output logic [DATAWIDTH-1:0] result
);

    logic [DATAWIDTH-1:0] sum_s;
    logic [DATAWIDTH-1:0] diff_s;

    assign sum_s  = opa + opb;
    assign diff_s = opa - opb;

    // Select the adder or subtractor path.
    always_comb begin
        result = sum_s;
        if (op == OP_SUB) begin
            result = diff_s;
        end else begin
            result = sum_s;
        end
    end

endmodule

// File: rtl/circuit2_decode.sv
// ---------------------------------------------------------------------------
// circuit2_decode
// Recovers operand b (and c where determinable) from a circuit2 result pair
// (x, z) and the known operand a, and reports which comparator outcomes are
// consistent with that pair. One shared add/sub unit is time-multiplexed by
// a five-state FSM: IDLE -> SUB_B -> ADD_D -> SUB_X -> DONE -> IDLE.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake (ready only in IDLE)
//   a, x, z           known operand and encoded results
//   out_valid/out_ready output handshake (valid only in DONE)
//   b, c, c_known     recovered operands; c meaningful only when c_known
//   hyp_mask          consistent hypotheses {eq, lt, gt}
// ---------------------------------------------------------------------------
module circuit2_decode
    import circuit2_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] x,
    input  logic [DATAWIDTH-1:0] z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] c,
    output logic                 c_known,
    output logic [2:0]           hyp_mask
);

    localparam logic [DATAWIDTH-1:0] ZERO     = {DATAWIDTH{1'b0}};
    localparam logic [DATAWIDTH-1:0] ALL_ONES = {DATAWIDTH{1'b1}};

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] a_q, a_d;
    logic [DATAWIDTH-1:0] x_q, x_d;
    logic [DATAWIDTH-1:0] z_q, z_d;
    logic [DATAWIDTH-1:0] bc_q, bc_d;
    logic [DATAWIDTH-1:0] dc_q, dc_d;
    logic [DATAWIDTH-1:0] b_q, b_d;
    logic [DATAWIDTH-1:0] c_q, c_d;
    logic                 c_known_q, c_known_d;
    logic [2:0]           hyp_mask_q, hyp_mask_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;

    logic                 alu_op_s;
    logic [DATAWIDTH-1:0] alu_a_s;
    logic [DATAWIDTH-1:0] alu_b_s;
    logic [DATAWIDTH-1:0] alu_res_s;

    logic                 gt_s;
    logic                 lt_s;
    logic                 eq_s;

    addsub_unit #(
        .DATAWIDTH (DATAWIDTH)
    ) u_addsub (
        .op     (alu_op_s),
        .opa    (alu_a_s),
        .opb    (alu_b_s),
        .result (alu_res_s)
    );

    // Hypothesis flags, evaluated from captured operands; only consumed in SUB_X.
    // lt excludes dc = all-ones because d < e is impossible in that case.
    always_comb begin
        gt_s = (dc_q > x_q);
        lt_s = ({dc_q[DATAWIDTH-2:0], 1'b0} == x_q) && (dc_q != ALL_ONES);
        eq_s = (z_q == {1'b0, x_q[DATAWIDTH-1:1]});
    end

    // Next-state, operand muxing for the shared unit, and output selection.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        x_d         = x_q;
        z_d         = z_q;
        bc_d        = bc_q;
        dc_d        = dc_q;
        b_d         = b_q;
        c_d         = c_q;
        c_known_d   = c_known_q;
        hyp_mask_d  = hyp_mask_q;
        out_valid_d = out_valid_q;
        alu_op_s    = OP_ADD;
        alu_a_s     = a_q;
        alu_b_s     = z_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    x_d     = x;
                    z_d     = z;
                    state_d = SUB_B;
                end else begin
                    state_d = IDLE;
                end
            end
            SUB_B: begin
                alu_op_s = OP_SUB;
                alu_a_s  = a_q;
                alu_b_s  = z_q;
                bc_d     = alu_res_s;
                state_d  = ADD_D;
            end
            ADD_D: begin
                alu_op_s = OP_ADD;
                alu_a_s  = a_q;
                alu_b_s  = bc_q;
                dc_d     = alu_res_s;
                state_d  = SUB_X;
            end
            SUB_X: begin
                // alu_res_s carries t = x - a in this state.
                alu_op_s    = OP_SUB;
                alu_a_s     = x_q;
                alu_b_s     = a_q;
                hyp_mask_d  = pack_hyp(eq_s, lt_s, gt_s);
                out_valid_d = 1'b1;
                state_d     = DONE;
                if (gt_s) begin
                    b_d       = bc_q;
                    c_d       = alu_res_s;
                    c_known_d = 1'b1;
                end else if (lt_s) begin
                    b_d       = bc_q;
                    c_d       = ZERO;
                    c_known_d = 1'b0;
                end else if (eq_s) begin
                    b_d       = alu_res_s;
                    c_d       = alu_res_s;
                    c_known_d = 1'b1;
                end else begin
                    b_d       = ZERO;
                    c_d       = ZERO;
                    c_known_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // Registered so in_ready tracks the state the FSM is about to enter.
        if (state_d == IDLE) begin
            in_ready_d = 1'b1;
        end else begin
            in_ready_d = 1'b0;
        end
    end

    // State, capture, intermediate and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= ZERO;
            x_q         <= ZERO;
            z_q         <= ZERO;
            bc_q        <= ZERO;
            dc_q        <= ZERO;
            b_q         <= ZERO;
            c_q         <= ZERO;
            c_known_q   <= 1'b0;
            hyp_mask_q  <= 3'b000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            x_q         <= x_d;
            z_q         <= z_d;
            bc_q        <= bc_d;
            dc_q        <= dc_d;
            b_q         <= b_d;
            c_q         <= c_d;
            c_known_q   <= c_known_d;
            hyp_mask_q  <= hyp_mask_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign b         = b_q;
    assign c         = c_q;
    assign c_known   = c_known_q;
    assign hyp_mask  = hyp_mask_q;

endmodule

// File: tb/tb_circuit2_decode.sv
// ---------------------------------------------------------------------------
// tb_circuit2_decode
// Directed bench for circuit2_decode. Inputs change and outputs are sampled
// on the falling clock edge; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_circuit2_decode;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] x;
    logic [31:0] z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] b;
    logic [31:0] c;
    logic        c_known;
    logic [2:0]  hyp_mask;

    int checks;
    int errors;

    circuit2_decode #(
        .DATAWIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .x         (x),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b         (b),
        .c         (c),
        .c_known   (c_known),
        .hyp_mask  (hyp_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = 32'd0; x = 32'd0; z = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (b !== 32'd0) begin errors++; $display("FAIL reset_b got %0h want 0", b); end
        checks++; if (c !== 32'd0) begin errors++; $display("FAIL reset_c got %0h want 0", c); end
        checks++; if (c_known !== 1'b0) begin errors++; $display("FAIL reset_c_known got %0b want 0", c_known); end
        checks++; if (hyp_mask !== 3'b000) begin errors++; $display("FAIL reset_hyp_mask got %b want 000", hyp_mask); end
    endtask

    // One full decode; early_ready holds out_ready high from acceptance on.
    task automatic test_decode(input string nm, input logic [31:0] av, input logic [31:0] xv,
                               input logic [31:0] zv, input logic [31:0] eb, input logic [31:0] ec,
                               input logic ek, input logic [2:0] em, input logic early_ready);
        logic exp_v;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s idle_in_ready got %0b want 1", nm, in_ready); end
        in_valid = 1'b1; a = av; x = xv; z = zv;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = early_ready;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s busy_in_ready got %0b want 0", nm, in_ready); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            exp_v = (i == 3) ? 1'b1 : 1'b0;
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL %s latency_cycle%0d out_valid got %0b want %0b", nm, i, out_valid, exp_v); end
        end
        checks++; if (b !== eb) begin errors++; $display("FAIL %s b got %0h want %0h", nm, b, eb); end
        checks++; if (c !== ec) begin errors++; $display("FAIL %s c got %0h want %0h", nm, c, ec); end
        checks++; if (c_known !== ek) begin errors++; $display("FAIL %s c_known got %0b want %0b", nm, c_known, ek); end
        checks++; if (hyp_mask !== em) begin errors++; $display("FAIL %s hyp_mask got %b want %b", nm, hyp_mask, em); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s release_out_valid got %0b want 0", nm, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s release_in_ready got %0b want 1", nm, in_ready); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1; a = 32'd10; x = 32'd12; z = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        // A competing request arrives while DONE is stalled; it must be dropped.
        in_valid = 1'b1; a = 32'd10; x = 32'd19; z = 32'd9;
        for (int i = 0; i < 6; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d out_valid got %0b want 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d in_ready got %0b want 0", i, in_ready); end
            checks++; if (b !== 32'd5 || c !== 32'd2) begin errors++; $display("FAIL bp_hold%0d b/c got %0h/%0h want 5/2", i, b, c); end
            checks++; if (hyp_mask !== 3'b001 || c_known !== 1'b1) begin errors++; $display("FAIL bp_hold%0d mask/known got %b/%0b want 001/1", i, hyp_mask, c_known); end
            if (i == 5) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got %0b want 1", in_ready); end
        repeat (4) @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_not_queued in_ready/out_valid got %0b/%0b want 1/0", in_ready, out_valid); end
        checks++; if (b !== 32'd5) begin errors++; $display("FAIL bp_not_queued b got %0h want 5", b); end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        in_valid = 1'b1; a = 32'd10; x = 32'd24; z = 32'd8;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        // FSM is in ADD_D here.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst out_valid got %0b want 0", out_valid); end
        checks++; if (b !== 32'd0 || c !== 32'd0) begin errors++; $display("FAIL midrst b/c got %0h/%0h want 0/0", b, c); end
        checks++; if (c_known !== 1'b0 || hyp_mask !== 3'b000) begin errors++; $display("FAIL midrst known/mask got %0b/%b want 0/000", c_known, hyp_mask); end
        repeat (4) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard out_valid got %0b want 0", out_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_decode("gt",        32'd10, 32'd12, 32'd5, 32'd5, 32'd2, 1'b1, 3'b001, 1'b0);
        test_decode("lt",        32'd10, 32'd24, 32'd8, 32'd2, 32'd0, 1'b0, 3'b010, 1'b0);
        test_decode("eq",        32'd10, 32'd19, 32'd9, 32'd9, 32'd9, 1'b1, 3'b100, 1'b0);
        test_decode("ambiguous", 32'd10, 32'd13, 32'd6, 32'd4, 32'd3, 1'b1, 3'b101, 1'b0);
        test_decode("none",      32'd1,  32'd7,  32'd0, 32'd0, 32'd0, 1'b0, 3'b000, 1'b0);
        // dc wraps to all-ones: lt must be suppressed even though dc<<1 == x.
        test_decode("dc_allones", 32'd0, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 3'b001, 1'b0);
        test_decode("early_ready", 32'd10, 32'd19, 32'd9, 32'd9, 32'd9, 1'b1, 3'b100, 1'b1);
        test_backpressure();
        test_decode("lt_before_rst", 32'd10, 32'd24, 32'd8, 32'd2, 32'd0, 1'b0, 3'b010, 1'b0);
        test_reset_mid_op();
        test_decode("gt_after_rst", 32'd10, 32'd12, 32'd5, 32'd5, 32'd2, 1'b1, 3'b001, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
